fpu_add_issue: RTL and testbench
================================

FPU_ADD_ISSUE -- requirements
Module: fpu_add_issue

Interface
REQ-001 SHALL have parameter PARAM_Fp_size, default 32, operand width in bits.
REQ-002 SHALL have parameter PARAM_Mantissa_size, default 23, fraction field width.
REQ-003 SHALL have parameter PARAM_Exponent_size, default 8, exponent field width.
REQ-004 SHALL have parameter TAG_W, default 5, request tag width.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-008 SHALL have port frm  input  3  CSR dynamic rounding mode.
REQ-009 SHALL have ports req_valid in 1, req_ready out 1, req_sub in 1 (0 add, 1 sub), req_rm in 3, req_rs1 in PARAM_Fp_size, req_rs2 in PARAM_Fp_size, req_tag in TAG_W.
REQ-010 SHALL have ports iss_valid out 1, iss_ready in 1, iss_rm out 3, iss_A out PARAM_Fp_size, iss_B out PARAM_Fp_size, iss_tag out TAG_W, iss_special out 1, iss_special_result out PARAM_Fp_size, iss_nv out 1, iss_illegal out 1.
REQ-011 SHALL have ports stat_issued out 32, stat_stall out 32.

Function
REQ-012 SHALL buffer requests in a 2-entry FIFO (count 0..2); push = req_valid & req_ready, pop = iss_valid & iss_ready.
REQ-013 SHALL drive req_ready = (count < 2) from registered state only; no combinational path from iss_ready to req_ready.
REQ-014 SHALL drive iss_valid = (count != 0), all iss_* fields from head entry; accepted request visible on iss_* the next cycle (latency 1).
REQ-015 SHALL allow simultaneous push and pop at count 1 (count stays 1, order preserved); at count 2 push is impossible.
REQ-016 SHALL resolve rounding at push: rm 111 selects frm sampled that cycle; otherwise req_rm; resolved value stored as iss_rm.
REQ-017 SHALL set iss_illegal=1, iss_special=1, iss_special_result=0 when resolved rm is 101, 110 or 111.
REQ-018 SHALL store iss_B = req_rs2 with sign bit inverted when req_sub=1; iss_A = req_rs1 unmodified.
REQ-019 SHALL flag NaN operand (exp all ones, fraction nonzero): iss_special=1, result 0x7FC00000; iss_nv=1 if either is signalling (fraction MSB 0).
REQ-020 SHALL flag effective inf minus inf (both inf, signs differ after REQ-018): iss_special=1, result 0x7FC00000, iss_nv=1.
REQ-021 SHALL flag single inf or same-sign infs: iss_special=1, result that inf, iss_nv=0.
REQ-022 SHALL flag both operands zero (exp and fraction 0): iss_special=1; result -0 if both negative, else +0 except -0 when resolved rm=010 and signs differ.
REQ-023 SHALL apply priority illegal-rm > NaN > inf > zero; otherwise iss_special=0, iss_nv=0, iss_special_result=0.
REQ-024 SHALL on flush clear count to 0 next cycle, dropping any same-cycle push; flush has priority over push and pop.
REQ-025 SHALL compute all classification at push and store it; head fields SHALL not change while iss_valid & ~iss_ready.

Reset
REQ-026 SHALL on reset set count=0, req_ready=0 during the reset cycle then 1, iss_valid=0, iss_rm=0, iss_A=0, iss_B=0, iss_tag=0, iss_special=0, iss_special_result=0, iss_nv=0, iss_illegal=0, stat_issued=0, stat_stall=0.
REQ-027 SHALL treat reset mid-operation as discarding all entries; reset has priority over flush.

Configuration
REQ-028 SHALL, when FPU_ADD_ISSUE_STATS_EN is defined, increment stat_issued on each pop and stat_stall each cycle iss_valid & ~iss_ready, both wrapping at 2^32.
REQ-029 SHALL, when FPU_ADD_ISSUE_STATS_EN is undefined, keep the stat ports present and tied to 0 with no counter logic.

Verification
REQ-030 SHALL cover: push rs1=0x3FA00000, rs2=0x3FB00000, rm=000, tag=3 -> next cycle iss_valid=1, iss_A=0x3FA00000, iss_B=0x3FB00000, iss_tag=3, iss_special=0.
REQ-031 SHALL cover: req_sub=1, rs2=0x3FC00000, rm=111, frm=010 -> iss_B=0xBFC00000, iss_rm=010.
REQ-032 SHALL cover: iss_ready=0, three back-to-back requests -> req_ready low after two pushes, third held; iss_ready=1 -> tags drain in order.
REQ-033 SHALL cover: rs1=0x7F800000, rs2=0x7F800000, req_sub=1 -> iss_special=1, result 0x7FC00000, iss_nv=1; rs1=0x7F800001 -> iss_nv=1; rs1=0x7FC00001 -> iss_nv=0.
REQ-034 SHALL cover: rs1=0x00000000, rs2=0x80000000 with rm=000 -> result 0x00000000; with rm=010 -> 0x80000000; rm=101 -> iss_illegal=1.
REQ-035 SHALL cover: flush with count=2 and concurrent push -> count=0, iss_valid=0 next cycle; with FPU_ADD_ISSUE_STATS_EN, stat_stall counts exactly stalled cycles.

Source files
------------

// File: rtl/fpu_add_issue.sv
// Issue buffer for the FP adder: a 2-entry FIFO that resolves rounding mode and classifies special operands at push.
// Optional FPU_ADD_ISSUE_STATS_EN enables the stat_issued / stat_stall counters; otherwise they read 0.
module fpu_add_issue #(
  parameter int PARAM_Fp_size       = 32,
  parameter int PARAM_Mantissa_size = 23,
  parameter int PARAM_Exponent_size = 8,
  parameter int TAG_W               = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [2:0]               frm,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_sub,
  input  logic [2:0]               req_rm,
  input  logic [PARAM_Fp_size-1:0] req_rs1,
  input  logic [PARAM_Fp_size-1:0] req_rs2,
  input  logic [TAG_W-1:0]         req_tag,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [2:0]               iss_rm,
  output logic [PARAM_Fp_size-1:0] iss_A,
  output logic [PARAM_Fp_size-1:0] iss_B,
  output logic [TAG_W-1:0]         iss_tag,
  output logic                     iss_special,
  output logic [PARAM_Fp_size-1:0] iss_special_result,
  output logic                     iss_nv,
  output logic                     iss_illegal,
  output logic [31:0]              stat_issued,
  output logic [31:0]              stat_stall
);
  localparam int W = PARAM_Fp_size;
  localparam int M = PARAM_Mantissa_size;
  localparam int E = PARAM_Exponent_size;
  localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

  typedef struct packed {
    logic [2:0]       rm;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [TAG_W-1:0] tag;
    logic             special;
    logic [W-1:0]     result;
    logic             nv;
    logic             illegal;
  } entry_t;

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid never depends on ready, and req_ready is a register so iss_ready cannot reach it.
  entry_t     mem [2];
  entry_t     new_e;
  logic [1:0] count;
  logic [1:0] count_next;
  logic       head;
  logic       tail;
  logic       rdy_q;
  logic       push;
  logic       pop;

  assign req_ready = rdy_q;
  assign iss_valid = (count != 2'd0);
  assign push      = req_valid & rdy_q;
  assign pop       = iss_valid & iss_ready;
  assign tail      = (count == 2'd0) ? head : ~head;

  // Operand classification of the request as it would be stored
  logic [2:0]   rm_res;
  logic [W-1:0] b_eff;
  logic         a_ones, b_ones, a_fnz, b_fnz;
  logic         a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic         rm_bad;

  assign rm_res = (req_rm == 3'b111) ? frm : req_rm;
  assign b_eff  = {req_rs2[W-1] ^ req_sub, req_rs2[W-2:0]};
  assign a_ones = &req_rs1[W-2:M];
  assign b_ones = &b_eff[W-2:M];
  assign a_fnz  = |req_rs1[M-1:0];
  assign b_fnz  = |b_eff[M-1:0];
  assign a_nan  = a_ones & a_fnz;
  assign b_nan  = b_ones & b_fnz;
  assign a_snan = a_nan & ~req_rs1[M-1];
  assign b_snan = b_nan & ~b_eff[M-1];
  assign a_inf  = a_ones & ~a_fnz;
  assign b_inf  = b_ones & ~b_fnz;
  assign a_zero = ~|req_rs1[W-2:0];
  assign b_zero = ~|b_eff[W-2:0];
  assign rm_bad = (rm_res == 3'b101) | (rm_res == 3'b110) | (rm_res == 3'b111);

  always_comb begin
    new_e     = '0;
    new_e.rm  = rm_res;
    new_e.a   = req_rs1;
    new_e.b   = b_eff;
    new_e.tag = req_tag;
    if (rm_bad) begin
      new_e.special = 1'b1;
      new_e.illegal = 1'b1;
    end else if (a_nan | b_nan) begin
      new_e.special = 1'b1;
      new_e.result  = QNAN;
      new_e.nv      = a_snan | b_snan;
    end else if (a_inf & b_inf & (req_rs1[W-1] != b_eff[W-1])) begin
      new_e.special = 1'b1;
      new_e.result  = QNAN;
      new_e.nv      = 1'b1;
    end else if (a_inf) begin
      new_e.special = 1'b1;
      new_e.result  = req_rs1;
    end else if (b_inf) begin
      new_e.special = 1'b1;
      new_e.result  = b_eff;
    end else if (a_zero & b_zero) begin
      new_e.special = 1'b1;
      // Exact zero sum: negative only when both are -0, or signs differ under round-down
      new_e.result  = {(req_rs1[W-1] & b_eff[W-1]) |
                       ((rm_res == 3'b010) & (req_rs1[W-1] ^ b_eff[W-1])),
                       {(W-1){1'b0}}};
    end
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      head   <= 1'b0;
      rdy_q  <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      count <= 2'd0;
      rdy_q <= 1'b1;
    end else begin
      if (push) mem[tail] <= new_e;
      if (pop) head <= ~head;
      count <= count_next;
      rdy_q <= (count_next < 2'd2);
    end
  end

  assign iss_rm             = mem[head].rm;
  assign iss_A              = mem[head].a;
  assign iss_B              = mem[head].b;
  assign iss_tag            = mem[head].tag;
  assign iss_special        = mem[head].special;
  assign iss_special_result = mem[head].result;
  assign iss_nv             = mem[head].nv;
  assign iss_illegal        = mem[head].illegal;

`ifdef FPU_ADD_ISSUE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued <= 32'd0;
      stat_stall  <= 32'd0;
    end else begin
      if (pop) stat_issued <= stat_issued + 32'd1;
      if (iss_valid & ~iss_ready) stat_stall <= stat_stall + 32'd1;
    end
  end
`else
  assign stat_issued = 32'd0;
  assign stat_stall  = 32'd0;
`endif

endmodule

// File: tb/tb_fpu_add_issue.sv
// Bench for fpu_add_issue: queue-based reference model checked every cycle, plus literal directed checks.
module tb_fpu_add_issue;
  localparam int EW = 107;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [2:0]  frm;
  logic        req_valid, req_ready, req_sub;
  logic [2:0]  req_rm;
  logic [31:0] req_rs1, req_rs2;
  logic [4:0]  req_tag;
  logic        iss_valid, iss_ready;
  logic [2:0]  iss_rm;
  logic [31:0] iss_A, iss_B, iss_special_result;
  logic [4:0]  iss_tag;
  logic        iss_special, iss_nv, iss_illegal;
  logic [31:0] stat_issued, stat_stall;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  logic [EW-1:0] exp_q[$];
  bit            m_ready = 0;
  logic [31:0]   m_issued = 0, m_stall = 0;
  logic [4:0]    got_tags[$];

  fpu_add_issue dut (
    .clk(clk), .reset(reset), .flush(flush), .frm(frm),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub), .req_rm(req_rm),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rm(iss_rm), .iss_A(iss_A), .iss_B(iss_B),
    .iss_tag(iss_tag), .iss_special(iss_special), .iss_special_result(iss_special_result),
    .iss_nv(iss_nv), .iss_illegal(iss_illegal),
    .stat_issued(stat_issued), .stat_stall(stat_stall)
  );

  always #5 clk = ~clk;

  // Reference classification of single-precision operands from field values
  function automatic logic [EW-1:0] model_entry(input logic sub, input logic [2:0] rm,
      input logic [31:0] a, input logic [31:0] b_in, input logic [4:0] tag, input logic [2:0] f);
    logic [2:0]  r;
    logic [31:0] b, res;
    logic        spec, nv, ill;
    int          ea, eb, fa, fb;
    bit          sa, sb;
    r  = (rm == 3'd7) ? f : rm;
    b  = sub ? (b_in ^ 32'h8000_0000) : b_in;
    sa = a[31]; sb = b[31];
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = int'(a[22:0]);  fb = int'(b[22:0]);
    spec = 0; nv = 0; ill = 0; res = 32'd0;
    if (r >= 3'd5) begin
      spec = 1; ill = 1;
    end else if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) begin
      spec = 1; res = 32'h7FC0_0000;
      nv = (ea == 255 && fa != 0 && fa < 32'h40_0000) || (eb == 255 && fb != 0 && fb < 32'h40_0000);
    end else if (ea == 255 && eb == 255 && sa != sb) begin
      spec = 1; res = 32'h7FC0_0000; nv = 1;
    end else if (ea == 255) begin
      spec = 1; res = a;
    end else if (eb == 255) begin
      spec = 1; res = b;
    end else if (ea == 0 && fa == 0 && eb == 0 && fb == 0) begin
      spec = 1;
      if (sa && sb) res = 32'h8000_0000;
      else if (sa != sb && r == 3'd2) res = 32'h8000_0000;
      else res = 32'h0000_0000;
    end
    return {r, a, b, tag, spec, res, nv, ill};
  endfunction

  // Model state update on the same edge the DUT samples
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_ready  = 0;
      m_issued = 0;
      m_stall  = 0;
    end else begin
`ifdef FPU_ADD_ISSUE_STATS_EN
      if (exp_q.size() != 0) begin
        if (iss_ready) m_issued = m_issued + 1;
        else           m_stall  = m_stall + 1;
      end
`endif
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() != 0 && iss_ready) void'(exp_q.pop_front());
        if (req_valid && m_ready)
          exp_q.push_back(model_entry(req_sub, req_rm, req_rs1, req_rs2, req_tag, frm));
      end
      m_ready = (exp_q.size() < 2);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (req_ready !== m_ready) begin
        n_fail++;
        $display("FAIL req_ready actual=%b required=%b t=%0t", req_ready, m_ready, $time);
      end
      n_tests++;
      if (iss_valid !== (exp_q.size() != 0)) begin
        n_fail++;
        $display("FAIL iss_valid actual=%b required=%b t=%0t", iss_valid, exp_q.size() != 0, $time);
      end
      if (exp_q.size() != 0) begin
        n_tests++;
        if ({iss_rm, iss_A, iss_B, iss_tag, iss_special, iss_special_result, iss_nv, iss_illegal} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL head actual=%h required=%h t=%0t",
            {iss_rm, iss_A, iss_B, iss_tag, iss_special, iss_special_result, iss_nv, iss_illegal}, exp_q[0], $time);
        end
      end
      n_tests++;
      if (stat_issued !== m_issued || stat_stall !== m_stall) begin
        n_fail++;
        $display("FAIL stats actual=%0d/%0d required=%0d/%0d t=%0t", stat_issued, stat_stall, m_issued, m_stall, $time);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sub, input logic [2:0] rm, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    req_valid = 1; req_sub = sub; req_rm = rm; req_rs1 = a; req_rs2 = b; req_tag = tag;
  endtask

  // Push one request into an empty buffer, check the head literally, then drain it
  task automatic push_check(input string name, input logic sub, input logic [2:0] rm,
      input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
      input logic [31:0] e_b, input logic [2:0] e_rm, input logic e_spec,
      input logic [31:0] e_res, input logic e_nv, input logic e_ill);
    iss_ready = 0;
    drive(sub, rm, a, b, tag);
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    chk({name, ".valid"},   {31'd0, iss_valid}, 32'd1);
    chk({name, ".A"},       iss_A, a);
    chk({name, ".B"},       iss_B, e_b);
    chk({name, ".tag"},     {27'd0, iss_tag}, {27'd0, tag});
    chk({name, ".rm"},      {29'd0, iss_rm}, {29'd0, e_rm});
    chk({name, ".special"}, {31'd0, iss_special}, {31'd0, e_spec});
    chk({name, ".result"},  iss_special_result, e_res);
    chk({name, ".nv"},      {31'd0, iss_nv}, {31'd0, e_nv});
    chk({name, ".illegal"}, {31'd0, iss_illegal}, {31'd0, e_ill});
    iss_ready = 1;
    @(posedge clk); #1;
    iss_ready = 0;
  endtask

  logic [31:0] op_tab [8] = '{32'h3F80_0000, 32'h0000_0000, 32'h8000_0000, 32'h7F80_0000,
                              32'hFF80_0000, 32'h7FC0_0001, 32'h7F80_0001, 32'hC040_0000};

  initial begin
    reset = 1; flush = 0; frm = 3'd0; iss_ready = 0;
    req_valid = 0; req_sub = 0; req_rm = 0; req_rs1 = 0; req_rs2 = 0; req_tag = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst.req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst.iss_valid", {31'd0, iss_valid}, 32'd0);
    chk("rst.iss_A", iss_A, 32'd0);
    chk("rst.iss_B", iss_B, 32'd0);
    chk("rst.flags", {27'd0, iss_rm, iss_special, iss_nv}, 32'd0);
    chk("rst.result", iss_special_result, 32'd0);
    chk("rst.stat", stat_issued | stat_stall, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    chk_en = 1;
    @(posedge clk); #1;

    push_check("basic", 0, 3'b000, 32'h3FA0_0000, 32'h3FB0_0000, 5'd3,
               32'h3FB0_0000, 3'b000, 0, 32'h0, 0, 0);
    frm = 3'b010;
    push_check("sub_dyn", 1, 3'b111, 32'h3F80_0000, 32'h3FC0_0000, 5'd7,
               32'hBFC0_0000, 3'b010, 0, 32'h0, 0, 0);
    frm = 3'b000;
    push_check("inf_m_inf", 1, 3'b000, 32'h7F80_0000, 32'h7F80_0000, 5'd1,
               32'hFF80_0000, 3'b000, 1, 32'h7FC0_0000, 1, 0);
    push_check("snan", 0, 3'b000, 32'h7F80_0001, 32'h3F80_0000, 5'd2,
               32'h3F80_0000, 3'b000, 1, 32'h7FC0_0000, 1, 0);
    push_check("qnan", 0, 3'b000, 32'h7FC0_0001, 32'h3F80_0000, 5'd4,
               32'h3F80_0000, 3'b000, 1, 32'h7FC0_0000, 0, 0);
    push_check("zero_rne", 0, 3'b000, 32'h0000_0000, 32'h8000_0000, 5'd5,
               32'h8000_0000, 3'b000, 1, 32'h0000_0000, 0, 0);
    push_check("zero_rdn", 0, 3'b010, 32'h0000_0000, 32'h8000_0000, 5'd6,
               32'h8000_0000, 3'b010, 1, 32'h8000_0000, 0, 0);
    push_check("rm101", 0, 3'b101, 32'h0000_0000, 32'h8000_0000, 5'd8,
               32'h8000_0000, 3'b101, 1, 32'h0000_0000, 0, 1);
    push_check("neg_inf", 0, 3'b001, 32'hFF80_0000, 32'h3F80_0000, 5'd9,
               32'h3F80_0000, 3'b001, 1, 32'hFF80_0000, 0, 0);
    push_check("b_inf_sub", 1, 3'b000, 32'h3F80_0000, 32'h7F80_0000, 5'd10,
               32'hFF80_0000, 3'b000, 1, 32'hFF80_0000, 0, 0);
    push_check("neg_zeros", 0, 3'b000, 32'h8000_0000, 32'h8000_0000, 5'd11,
               32'h8000_0000, 3'b000, 1, 32'h8000_0000, 0, 0);
    frm = 3'b110;
    push_check("frm_bad", 0, 3'b111, 32'h3F80_0000, 32'h4000_0000, 5'd12,
               32'h4000_0000, 3'b110, 1, 32'h0, 0, 1);
    frm = 3'b000;

    // Three back-to-back requests against a stalled consumer, then drain in order
    iss_ready = 0;
    drive(0, 3'b000, 32'h3F80_0000, 32'h3F80_0000, 5'd20);
    @(posedge clk); #1;
    req_tag = 5'd21;
    @(posedge clk); #1;
    req_tag = 5'd22;
    @(posedge clk); #1;
    @(negedge clk);
    chk("full.req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    iss_ready = 1;
    got_tags.delete();
    for (int i = 0; i < 8; i++) begin
      bit acc;
      @(negedge clk);
      if (iss_valid) got_tags.push_back(iss_tag);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      if (acc) req_valid = 0;
    end
    chk("drain.count", got_tags.size(), 32'd3);
    for (int i = 0; i < 3 && i < got_tags.size(); i++)
      chk("drain.tag", {27'd0, got_tags[i]}, 32'd20 + i);
    chk("drain.pending", {31'd0, req_valid}, 32'd0);

    // Flush with a full buffer and a concurrent push
    iss_ready = 0;
    drive(0, 3'b000, 32'h4000_0000, 32'h4000_0000, 5'd24);
    @(posedge clk); #1;
    req_tag = 5'd25;
    @(posedge clk); #1;
    req_tag = 5'd26;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    req_valid = 0;
    @(negedge clk);
    chk("flush.iss_valid", {31'd0, iss_valid}, 32'd0);
    chk("flush.req_ready", {31'd0, req_ready}, 32'd1);
    push_check("post_flush", 0, 3'b011, 32'h4040_0000, 32'hC040_0000, 5'd27,
               32'hC040_0000, 3'b011, 0, 32'h0, 0, 0);

    // Mixed traffic from an operand table
    for (int i = 0; i < 60; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      iss_ready = 1'($urandom_range(0, 1));
      req_sub   = 1'($urandom_range(0, 1));
      req_rm    = 3'($urandom_range(0, 7));
      frm       = 3'($urandom_range(0, 7));
      req_rs1   = op_tab[$urandom_range(0, 7)];
      req_rs2   = op_tab[$urandom_range(0, 7)];
      req_tag   = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
    end

    // Reset while entries are buffered
    req_valid = 1; iss_ready = 0;
    @(posedge clk); #1;
    reset = 1;
    req_valid = 0;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("midrst.iss_valid", {31'd0, iss_valid}, 32'd0);
    chk("midrst.stat", stat_issued | stat_stall, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst.req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
